seq_add16: RTL and testbench

Multi-cycle wide adder that reuses the team's structural 4-bit ripple adder (`fullader`) one nibble per clock. It adds two WIDTH-bit operands with carry-in, from LSB nibble to MSB nibble. It sits directly upstream of the 4-bit adder: it slices, feeds and chains carries into that adder, then collects its sum and carry outputs into a registered wide result with a start/done handshake.

---
 rtl/seq_add_pkg.sv | 27 ++
 rtl/fullader.sv | 24 ++
 rtl/seq_add16.sv | 139 +++++++++++++
 tb/tb_seq_add16.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seq_add_pkg.sv
// Shared definitions for the nibble-serial wide adder.
package seq_add_pkg;

  // Width of one adder step; the reused ripple adder is four bits wide.
  localparam int NIB = 4;

  // Controller states.
  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Width of the nibble index counter for a given operand width (at least 1 bit).
  function automatic int idx_width(input int width);
    int steps;
    int w;
    steps = width / NIB;
    w     = $clog2(steps);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/fullader.sv
// Structural 4-bit ripple-carry adder: s = a + b + cin, c = carry out of bit 3.
module fullader (
  output logic [3:0] s,
  output logic       c,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin
);

  logic [4:0] cy_s;

  assign cy_s[0] = cin;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_bit
      assign s[i]      = a[i] ^ b[i] ^ cy_s[i];
      assign cy_s[i+1] = (a[i] & b[i]) | (cy_s[i] & (a[i] ^ b[i]));
    end
  endgenerate

  assign c = cy_s[4];

endmodule

// File: rtl/seq_add16.sv
// Multi-cycle wide adder: one shared 4-bit ripple adder processes one nibble
// per clock, LSB nibble first, with a start/busy/done handshake.
module seq_add16
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / NIB;
  localparam int IW = idx_width(WIDTH);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [NIB-1:0]   nib_a_s;
  logic [NIB-1:0]   nib_b_s;
  logic [NIB-1:0]   add_sum_s;
  logic             add_carry_s;

  // Slice the current nibble of each frozen operand for the shared adder.
  always_comb begin
    nib_a_s = a_q[idx_q*NIB +: NIB];
    nib_b_s = b_q[idx_q*NIB +: NIB];
  end

  fullader u_nib_add (
    .s   (add_sum_s),
    .c   (add_carry_s),
    .a   (nib_a_s),
    .b   (nib_b_s),
    .cin (carry_q)
  );

  // Next-state and datapath control: capture on accept, one nibble per RUN cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = {IW{1'b0}};
          state_d = S_RUN;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        sum_d[idx_q*NIB +: NIB] = add_sum_s;
        carry_d                 = add_carry_s;
        if (idx_q == IDX_LAST) begin
          // Final nibble: publish carry and signed overflow from the captured MSBs.
          idx_d   = {IW{1'b0}};
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cout_d  = add_carry_s;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                    (add_sum_s[NIB-1] != a_q[WIDTH-1]);
        end else begin
          idx_d   = idx_q + IW'(1);
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = {IW{1'b0}};
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= {IW{1'b0}};
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      carry_q <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_seq_add16.sv
// Self-checking bench for seq_add16: directed vectors, randomized operations,
// ignored restarts, back-to-back accepts and mid-operation reset.
module tb_seq_add16;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_checks;
  int n_errors;

  seq_add16 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain wide arithmetic on the operands.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                                           input logic ci);
    logic [W:0] full;
    logic       v;
    full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
    v    = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
    return {v, full};
  endfunction

  // One operation, entered and left on a negedge.
  // mode 0: plain; mode 1: disturb start/a/b/cin during RUN; mode 2: keep start high.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                       input int mode);
    logic [W+1:0] r;
    r     = ref_add(av, bv, ci);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = ci;
    @(posedge clk);
    @(negedge clk);
    check_eq("busy_after_accept", 32'(busy), 32'd1);
    check_eq("done_after_accept", 32'(done), 32'd0);
    if (mode != 2) start = 1'b0;
    for (int c = 1; c <= N; c++) begin
      if (mode == 1) begin
        start = 1'($urandom_range(1, 0));
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom_range(1, 0));
      end
      @(posedge clk);
      @(negedge clk);
      if (c < N) begin
        check_eq("busy_run", 32'(busy), 32'd1);
        check_eq("done_run", 32'(done), 32'd0);
      end else begin
        check_eq("busy_done", 32'(busy), 32'd0);
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("sum", 32'(sum), 32'(r[W-1:0]));
        check_eq("cout", 32'(cout), 32'(r[W]));
        check_eq("ovf", 32'(ovf), 32'(r[W+1]));
      end
    end
    if (mode != 2) start = 1'b0;
  endtask

  // Plain operation followed by one idle cycle: no extra done, results held.
  task automatic op_and_idle(input logic [W-1:0] av, input logic [W-1:0] bv, input logic ci,
                             input int mode);
    logic [W+1:0] r;
    r = ref_add(av, bv, ci);
    do_op(av, bv, ci, mode);
    @(posedge clk);
    @(negedge clk);
    check_eq("done_single", 32'(done), 32'd0);
    check_eq("busy_idle", 32'(busy), 32'd0);
    check_eq("sum_hold", 32'(sum), 32'(r[W-1:0]));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    a        = '0;
    b        = '0;
    cin      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_cout", 32'(cout), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors.
    op_and_idle(16'h0001, 16'h0001, 1'b0, 0);
    op_and_idle(16'hFFFF, 16'h0001, 1'b0, 0);
    op_and_idle(16'h7FFF, 16'h0001, 1'b0, 0);
    op_and_idle(16'h0F0F, 16'h00F1, 1'b1, 0);
    op_and_idle(16'h8000, 16'h8000, 1'b0, 0);
    op_and_idle(16'hFFFF, 16'hFFFF, 1'b1, 0);

    // Randomized operations.
    for (int i = 0; i < 20; i++) begin
      op_and_idle(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), 0);
    end

    // Inputs disturbed during RUN must not affect the result.
    for (int i = 0; i < 6; i++) begin
      op_and_idle(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), 1);
    end

    // Back-to-back: start held high, new operands presented in each done cycle.
    for (int i = 0; i < 8; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom_range(1, 0)), 2);
    end
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("b2b_tail_done", 32'(done), 32'd0);
    check_eq("b2b_tail_busy", 32'(busy), 32'd0);

    // Reset during the second RUN cycle aborts without a done pulse.
    op_and_idle(16'h1234, 16'h4321, 1'b1, 0);
    start = 1'b1;
    a     = 16'hABCD;
    b     = 16'h1111;
    cin   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_sum", 32'(sum), 32'd0);
    check_eq("abort_cout", 32'(cout), 32'd0);
    check_eq("abort_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_eq("abort_no_done", 32'(done), 32'd0);
    end
    op_and_idle(16'hABCD, 16'h1111, 1'b1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
